// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to instruction memory,
// buffers returned words together with their PC and hands them to decode. A redirect flushes
// the buffer and arranges for responses still in flight to be discarded as they return.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instruction,
   input  logic        id_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(FIFO_DEPTH - 1);
   localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {StBoot, StRun} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;

   // PCs of accepted requests awaiting their response, oldest at pend_rd_q
   logic [31:0]     pend_pc_q [FIFO_DEPTH];
   logic [IW-1:0]   pend_wr_q, pend_wr_d;
   logic [IW-1:0]   pend_rd_q, pend_rd_d;

   // Instruction buffer presented to decode
   logic [31:0]     buf_pc_q  [FIFO_DEPTH];
   logic [31:0]     buf_ins_q [FIFO_DEPTH];
   logic [IW-1:0]   buf_wr_q, buf_wr_d;
   logic [IW-1:0]   buf_rd_q, buf_rd_d;
   logic [CW-1:0]   buf_cnt_q, buf_cnt_d;

   logic [CW:0]     credit_used;
   logic [31:0]     redirect_base;
   logic            accept;
   logic            rsp;
   logic            push;
   logic            pop;

   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Request/response/handshake qualifiers and the decode-facing outputs
   always_comb begin
      redirect_base  = redirect_pc & ~32'h0000_0003;
      credit_used    = (CW + 1)'(outstanding_q) + (CW + 1)'(buf_cnt_q);
      // Outstanding plus buffered words are capped so every response is guaranteed a slot
      imem_req       = (state_q == StRun) && !redirect_valid && (credit_used < DEPTH_EXT);
      imem_addr      = pc_q;
      accept         = imem_req && imem_ready;
      // A response with nothing outstanding is a protocol error and is ignored
      rsp            = imem_rvalid && (outstanding_q != '0);
      push           = rsp && !redirect_valid && (drop_q == '0);
      id_valid       = (buf_cnt_q != '0);
      pop            = id_valid && id_ready && !redirect_valid;
      id_pc          = id_valid ? buf_pc_q[buf_rd_q]  : 32'h0;
      id_instruction = id_valid ? buf_ins_q[buf_rd_q] : 32'h0;
   end

   // Next-state for FSM, PC and in-flight bookkeeping
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      pend_wr_d     = pend_wr_q;
      pend_rd_d     = pend_rd_q;

      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StBoot;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_base;
      end else if (accept) begin
         pc_d = pc_q + 32'd4;
      end

      if (accept) begin
         pend_wr_d = idx_inc(pend_wr_q);
      end
      // Dropped responses still retire their pending PC
      if (rsp) begin
         pend_rd_d = idx_inc(pend_rd_q);
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);

      // Everything still in flight after this cycle belongs to the old stream
      if (redirect_valid) begin
         drop_d = outstanding_q - CW'(rsp);
      end else if (rsp && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end
   end

   // Next-state for the instruction buffer pointers and occupancy
   always_comb begin
      buf_wr_d  = buf_wr_q;
      buf_rd_d  = buf_rd_q;
      buf_cnt_d = buf_cnt_q;
      if (redirect_valid) begin
         buf_wr_d  = '0;
         buf_rd_d  = '0;
         buf_cnt_d = '0;
      end else begin
         if (push) begin
            buf_wr_d = idx_inc(buf_wr_q);
         end
         if (pop) begin
            buf_rd_d = idx_inc(buf_rd_q);
         end
         buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         pend_wr_q     <= '0;
         pend_rd_q     <= '0;
         buf_wr_q      <= '0;
         buf_rd_q      <= '0;
         buf_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         pend_wr_q     <= pend_wr_d;
         pend_rd_q     <= pend_rd_d;
         buf_wr_q      <= buf_wr_d;
         buf_rd_q      <= buf_rd_d;
         buf_cnt_q     <= buf_cnt_d;
      end
   end

   // Pending-PC and instruction buffer storage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            pend_pc_q[i] <= 32'h0;
            buf_pc_q[i]  <= 32'h0;
            buf_ins_q[i] <= 32'h0;
         end
      end else begin
         if (accept) begin
            pend_pc_q[pend_wr_q] <= pc_q;
         end
         if (push) begin
            buf_pc_q[buf_wr_q]  <= pend_pc_q[pend_rd_q];
            buf_ins_q[buf_wr_q] <= imem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with an in-order instruction memory model.
module tb_instruction_fetch_stage;

   localparam logic [31:0] KEY = 32'h1357_9BDF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instruction;
   logic        id_ready = 1'b1;

   logic        mem_auto = 1'b1;
   logic [31:0] mq[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_ins[$];
   logic [31:0] acc_q[$];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   instruction_fetch_stage dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_instruction (id_instruction),
      .id_ready       (id_ready)
   );

   always #5 clock = ~clock;

   // Memory: queue accepted addresses, retire one per returned word
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
      end else begin
         if (imem_rvalid) void'(mq.pop_front());
         if (imem_req && imem_ready) mq.push_back(imem_addr);
      end
   end

   // Memory: return the oldest queued word one cycle after acceptance (when enabled)
   always @(negedge clock) begin
      if (reset && mem_auto && mq.size() != 0) begin
         imem_rvalid <= 1'b1;
         imem_rdata  <= mq[0] ^ KEY;
      end else begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
      end
   end

   // Monitor: record consumed words and accepted fetch addresses
   always @(posedge clock) begin
      if (reset) begin
         if (id_valid && id_ready && !redirect_valid) begin
            got_pc.push_back(id_pc);
            got_ins.push_back(id_instruction);
         end
         if (imem_req && imem_ready) acc_q.push_back(imem_addr);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_words(input int n);
      for (int c = 0; c < 60 && got_pc.size() < n; c++) tick();
      vectors++;
      if (got_pc.size() < n) begin
         miscompares++;
         $display("FAIL wait_words: got %0d words, want %0d", got_pc.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) tick();
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
      vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
      vectors++; if (id_instruction !== 32'h0) begin miscompares++; $display("FAIL rst_id_ins: got %h want 0", id_instruction); end
      reset = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b want 0", imem_req); end
      tick();
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL run_req: got %b want 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL run_addr: got %h want 0", imem_addr); end
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL run_id_valid: got %b want 0", id_valid); end
   endtask

   task automatic test_streaming();
      wait_words(8);
      for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
         vectors++;
         if (got_pc[i] !== 32'(i * 4) || got_ins[i] !== (32'(i * 4) ^ KEY) || acc_q[i] !== 32'(i * 4)) begin
            miscompares++;
            $display("FAIL stream[%0d]: got pc %h ins %h addr %h want pc/addr %h ins %h",
                     i, got_pc[i], got_ins[i], acc_q[i], 32'(i * 4), 32'(i * 4) ^ KEY);
         end
      end
   endtask

   task automatic test_backpressure();
      int am, gm;
      id_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0;
      #1;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_redir_req: got %b want 0", imem_req); end
      tick();
      redirect_valid = 1'b0;
      am = acc_q.size();
      gm = got_pc.size();
      repeat (10) tick();
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req: got %b want 0", imem_req); end
      vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b want 1", id_valid); end
      vectors++; if (id_pc !== 32'h0 || id_instruction !== KEY) begin miscompares++; $display("FAIL bp_head: got %h/%h want 0/%h", id_pc, id_instruction, KEY); end
      vectors++; if (acc_q.size() - am != 2) begin miscompares++; $display("FAIL bp_accepts: got %0d want 2", acc_q.size() - am); end
      vectors++; if (got_pc.size() != gm) begin miscompares++; $display("FAIL bp_consumed: got %0d want 0", got_pc.size() - gm); end
      id_ready = 1'b1;
      wait_words(gm + 3);
      for (int i = 0; i < 3 && gm + i < got_pc.size(); i++) begin
         vectors++;
         if (got_pc[gm+i] !== 32'(i * 4) || got_ins[gm+i] !== (32'(i * 4) ^ KEY)) begin
            miscompares++;
            $display("FAIL bp_drain[%0d]: got %h/%h want %h", i, got_pc[gm+i], got_ins[gm+i], 32'(i * 4));
         end
      end
   endtask

   task automatic test_redirect_inflight();
      int am, gm;
      mem_auto = 1'b0;
      repeat (6) tick();
      vectors++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin miscompares++; $display("FAIL if_stall: got req %b valid %b want 0 0", imem_req, id_valid); end
      vectors++; if (mq.size() != 2) begin miscompares++; $display("FAIL if_inflight: got %0d want 2", mq.size()); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL if_redir_valid: got %b want 0", id_valid); end
      tick();
      redirect_valid = 1'b0;
      mem_auto = 1'b1;
      am = acc_q.size();
      gm = got_pc.size();
      vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL if_addr: got %h want 100", imem_addr); end
      wait_words(gm + 1);
      if (got_pc.size() > gm) begin
         vectors++; if (got_pc[gm] !== 32'h100 || got_ins[gm] !== (32'h100 ^ KEY)) begin miscompares++; $display("FAIL if_first: got %h/%h want 100", got_pc[gm], got_ins[gm]); end
         vectors++; if (acc_q[am] !== 32'h100) begin miscompares++; $display("FAIL if_fetch: got %h want 100", acc_q[am]); end
      end
   endtask

   task automatic test_redirect_rvalid();
      int gm;
      for (int c = 0; c < 10 && mq.size() == 0; c++) tick();
      vectors++; if (mq.size() == 0) begin miscompares++; $display("FAIL rv_setup: got 0 in flight want >=1"); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      gm = got_pc.size();
      vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL rv_addr: got %h want 200", imem_addr); end
      wait_words(gm + 2);
      if (got_pc.size() >= gm + 2) begin
         vectors++; if (got_pc[gm] !== 32'h200 || got_ins[gm] !== (32'h200 ^ KEY)) begin miscompares++; $display("FAIL rv_first: got %h/%h want 200", got_pc[gm], got_ins[gm]); end
         vectors++; if (got_pc[gm+1] !== 32'h204) begin miscompares++; $display("FAIL rv_second: got %h want 204", got_pc[gm+1]); end
      end
   endtask

   task automatic test_wrap();
      int am, gm;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      am = acc_q.size();
      gm = got_pc.size();
      vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
      wait_words(gm + 3);
      if (got_pc.size() >= gm + 3) begin
         vectors++; if (acc_q[am] !== 32'hFFFF_FFFC || acc_q[am+1] !== 32'h0) begin miscompares++; $display("FAIL wrap_fetch: got %h,%h want fffffffc,0", acc_q[am], acc_q[am+1]); end
         vectors++; if (got_pc[gm] !== 32'hFFFF_FFFC || got_pc[gm+1] !== 32'h0 || got_pc[gm+2] !== 32'h4) begin miscompares++; $display("FAIL wrap_pcs: got %h,%h,%h want fffffffc,0,4", got_pc[gm], got_pc[gm+1], got_pc[gm+2]); end
         vectors++; if (got_ins[gm+1] !== KEY) begin miscompares++; $display("FAIL wrap_ins: got %h want %h", got_ins[gm+1], KEY); end
      end
   endtask

   task automatic test_back_to_back();
      int gm;
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect_pc = 32'h404;
      tick();
      redirect_valid = 1'b0;
      gm = got_pc.size();
      vectors++; if (imem_addr !== 32'h404) begin miscompares++; $display("FAIL b2b_addr: got %h want 404", imem_addr); end
      wait_words(gm + 2);
      if (got_pc.size() >= gm + 2) begin
         vectors++; if (got_pc[gm] !== 32'h404 || got_pc[gm+1] !== 32'h408) begin miscompares++; $display("FAIL b2b_pcs: got %h,%h want 404,408", got_pc[gm], got_pc[gm+1]); end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_rvalid();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1);
   end

endmodule
